sprite_bounce: RTL and testbench
================================

Name: sprite_bounce

Overview:
- Moving-sprite engine; sits directly upstream of screen_gen and consumes the same col/row/valid/VSYNC produced by the vga timing stage.
- Holds a rectangular sprite position and advances it once per N frames during vertical sync, reflecting off the active-area edges.
- Outputs a registered per-pixel hit flag and 6-bit colour; screen_gen merges these into its rgb.

Parameters:
- H_ACTIVE, 640, active columns
- V_ACTIVE, 480, active rows
- SPR_W, 16, sprite width in pixels
- SPR_H, 16, sprite height in pixels
- STEP, 2, pixels moved per update on each axis (1..SPR_W)
- X0, 100, reset x position (top-left)
- Y0, 50, reset y position (top-left)
- FRAME_DIV, 1, frames per position update (1..255)
- SPR_RGB, 6'b110000, sprite colour
- BG_RGB, 6'b000000, colour when not hit

Ports:
- clk  in  1  pixel clock (PLL output)
- rst_n  in  1  asynchronous active-low reset
- col  in  10  current column from vga timing
- row  in  10  current row from vga timing
- valid  in  1  high in active video
- VSYNC  in  1  vertical sync from vga timing, active-low
- enable  in  1  1 = motion on, 0 = freeze position
- hit  out  1  registered: pixel lies inside sprite
- rgb  out  6  registered: SPR_RGB on hit, else BG_RGB; 0 when not valid
- x_pos  out  10  current sprite left column
- y_pos  out  10  current sprite top row
- frame_tick  out  1  one-cycle pulse when an update is committed

Behaviour:
- Clock/reset: one clock, clk; rst_n asynchronous active-low. All flops clear on rst_n low.
- Reset values: hit=0, rgb=0, x_pos=X0, y_pos=Y0, frame_tick=0, dir_x=+1, dir_y=+1, frame counter=0, FSM=IDLE, vsync_d=1.
- Frame edge: vsync_d registers VSYNC; edge = vsync_d & ~VSYNC (falling edge of VSYNC). Exactly one edge per frame.
- Frame divider: on each edge, fcnt increments; when fcnt == FRAME_DIV-1 it wraps to 0 and an update is requested. The divider runs regardless of enable.
- FSM states: IDLE, UPD_X, UPD_Y, COMMIT.
  - IDLE -> UPD_X on an update request with enable=1. A request with enable=0 is dropped and the FSM stays in IDLE.
  - UPD_X -> UPD_Y -> COMMIT -> IDLE, unconditionally, one cycle each.
  - frame_tick=1 only in the cycle the FSM leaves COMMIT.
  - Edges arriving while the FSM is not in IDLE are impossible in practice (frame length >> 4 cycles). If one does arrive, the divider still counts it but the update request is ignored.
- UPD_X arithmetic, 11-bit intermediate, no wrap:
  - dir_x=+1: if x_pos+STEP+SPR_W >= H_ACTIVE then x_pos=H_ACTIVE-SPR_W and dir_x=-1; else x_pos+=STEP.
  - dir_x=-1: if x_pos <= STEP then x_pos=0 and dir_x=+1; else x_pos-=STEP.
- UPD_Y: same rules using y_pos, dir_y, SPR_H and V_ACTIVE.
- Corner hit: both axes reflect in the same update; each axis is handled independently.
- Position changes only during VSYNC low (blanking), so there is no tearing within a frame.
- Pixel path, 1-cycle latency:
  - hit <= valid & (col >= x_pos) & (col < x_pos+SPR_W) & (row >= y_pos) & (row < y_pos+SPR_H), compared in 11 bits.
  - rgb <= !valid ? 0 : (hit_comb ? SPR_RGB : BG_RGB).
- Reset mid-update: the FSM returns to IDLE and the position returns to X0/Y0. A half-applied update is not kept.
- enable deasserted mid-update: the in-flight update completes. Only new requests are gated.

Test Plan:
- Reset then 1 frame, STEP=2, FRAME_DIV=1, enable=1: x_pos 100->102, y_pos 50->52; frame_tick pulses once, 4 cycles after the VSYNC falling edge.
- Preload x_pos=622, dir_x=+1 (H_ACTIVE=640, SPR_W=16), 1 update: x_pos=624 and dir_x=-1; next update gives x_pos=622.
- Left/top edge at x_pos=1, y_pos=2, dir -1/-1, STEP=2: after update x_pos=0 and y_pos=0, both directions become +1; the following update gives 2/2.
- Pixel hit at x=100, y=50, valid=1:
  - col=100,row=50 -> hit=1, rgb=6'b110000 one cycle later.
  - col=116,row=50 -> hit=0, rgb=0.
  - col=99 -> hit=0.
  - valid=0 inside the box -> rgb=0.
- FRAME_DIV=3: 6 VSYNC edges give exactly 2 updates (x_pos 100->104); with enable=0 for all 6 edges, x_pos stays 100 and there is no frame_tick.
- Assert rst_n low during UPD_Y, asynchronously mid-cycle: outputs clear immediately; after release, x_pos=100, y_pos=50, FSM=IDLE.

Source files
------------

// File: rtl/sprite_bounce.sv
// rtl/sprite_bounce.sv - bouncing rectangular sprite engine with registered per-pixel hit/colour
module sprite_bounce #(
   parameter int          H_ACTIVE  = 640,
   parameter int          V_ACTIVE  = 480,
   parameter int          SPR_W     = 16,
   parameter int          SPR_H     = 16,
   parameter int          STEP      = 2,
   parameter int          X0        = 100,
   parameter int          Y0        = 50,
   parameter int          FRAME_DIV = 1,
   parameter logic [5:0]  SPR_RGB   = 6'b110000,
   parameter logic [5:0]  BG_RGB    = 6'b000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  col,
   input  logic [9:0]  row,
   input  logic        valid,
   input  logic        VSYNC,
   input  logic        enable,
   output logic        hit,
   output logic [5:0]  rgb,
   output logic [9:0]  x_pos,
   output logic [9:0]  y_pos,
   output logic        frame_tick
);

   localparam logic [10:0] H_A   = 11'(H_ACTIVE);
   localparam logic [10:0] V_A   = 11'(V_ACTIVE);
   localparam logic [10:0] SW    = 11'(SPR_W);
   localparam logic [10:0] SH    = 11'(SPR_H);
   localparam logic [10:0] STP   = 11'(STEP);
   localparam logic [9:0]  X_RST = 10'(X0);
   localparam logic [9:0]  Y_RST = 10'(Y0);
   localparam logic [7:0]  FD_M1 = 8'(FRAME_DIV - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPD_X  = 2'd1,
      UPD_Y  = 2'd2,
      COMMIT = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic        vsync_d;
   logic        frame_edge;
   logic [7:0]  fcnt;
   logic        upd_req;
   logic        dir_x;
   logic        dir_y;
   logic [10:0] x_step;
   logic [10:0] y_step;
   logic        hit_comb;

   // Returns {new_dir, new_pos}; dir 1 means moving toward larger coordinates.
   function automatic logic [10:0] next_axis(
      input logic [9:0]  p,
      input logic        d,
      input logic [10:0] span,
      input logic [10:0] size
   );
      logic [10:0] p11;
      p11 = {1'b0, p};
      if (d) begin
         if (p11 + STP + size >= span)
            return {1'b0, 10'(span - size)};
         else
            return {1'b1, 10'(p11 + STP)};
      end else begin
         if (p11 <= STP)
            return {1'b1, 10'd0};
         else
            return {1'b0, 10'(p11 - STP)};
      end
   endfunction

   assign frame_edge = vsync_d & ~VSYNC;
   assign upd_req    = frame_edge && (fcnt == FD_M1);
   assign x_step     = next_axis(x_pos, dir_x, H_A, SW);
   assign y_step     = next_axis(y_pos, dir_y, V_A, SH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_d <= 1'b1;
         fcnt    <= 8'd0;
      end else begin
         vsync_d <= VSYNC;
         if (frame_edge)
            fcnt <= (fcnt == FD_M1) ? 8'd0 : fcnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Requests arriving outside IDLE are dropped; enable only gates the start.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (upd_req && enable) state_nx = UPD_X;
         UPD_X:   state_nx = UPD_Y;
         UPD_Y:   state_nx = COMMIT;
         COMMIT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_pos      <= X_RST;
         y_pos      <= Y_RST;
         dir_x      <= 1'b1;
         dir_y      <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= (state == COMMIT);
         if (state == UPD_X) begin
            x_pos <= x_step[9:0];
            dir_x <= x_step[10];
         end
         if (state == UPD_Y) begin
            y_pos <= y_step[9:0];
            dir_y <= y_step[10];
         end
      end
   end

   always_comb begin
      hit_comb = valid
               && ({1'b0, col} >= {1'b0, x_pos})
               && ({1'b0, col} <  {1'b0, x_pos} + SW)
               && ({1'b0, row} >= {1'b0, y_pos})
               && ({1'b0, row} <  {1'b0, y_pos} + SH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit <= 1'b0;
         rgb <= 6'd0;
      end else begin
         hit <= hit_comb;
         rgb <= !valid ? 6'd0 : (hit_comb ? SPR_RGB : BG_RGB);
      end
   end

endmodule

// File: tb/tb_sprite_bounce.sv
// tb/tb_sprite_bounce.sv - scoreboard bench for sprite_bounce motion, divider, reset and pixel path
module tb_sprite_bounce;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] col = '0;
   logic [9:0] row = '0;
   logic       valid = 1'b0;
   logic       VSYNC = 1'b1;
   logic       enable = 1'b1;

   logic       hit_a, tick_a, hit_3, tick_3, hit_e, tick_e;
   logic [5:0] rgb_a, rgb_3, rgb_e;
   logic [9:0] x_a, y_a, x_3, y_3, x_e, y_e;

   int total = 0;
   int bad = 0;
   int cnt_a, cnt_3, cnt_e, last_lat;
   int mx, my, mdx, mdy;
   logic [19:0] sb[$];

   always #5 clk = ~clk;

   sprite_bounce dut (
      .clk(clk), .rst_n(rst_n), .col(col), .row(row), .valid(valid), .VSYNC(VSYNC),
      .enable(enable), .hit(hit_a), .rgb(rgb_a), .x_pos(x_a), .y_pos(y_a), .frame_tick(tick_a)
   );

   sprite_bounce #(.FRAME_DIV(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .col(col), .row(row), .valid(valid), .VSYNC(VSYNC),
      .enable(enable), .hit(hit_3), .rgb(rgb_3), .x_pos(x_3), .y_pos(y_3), .frame_tick(tick_3)
   );

   // Small field arranged so the sprite sits at x=1,y=2 moving up-left after 10 updates.
   sprite_bounce #(.H_ACTIVE(21), .V_ACTIVE(22), .SPR_W(4), .SPR_H(4), .X0(13), .Y0(14)) dute (
      .clk(clk), .rst_n(rst_n), .col(col), .row(row), .valid(valid), .VSYNC(VSYNC),
      .enable(enable), .hit(hit_e), .rgb(rgb_e), .x_pos(x_e), .y_pos(y_e), .frame_tick(tick_e)
   );

   function automatic int model_axis(input int p, input int d, input int span, input int size,
                                     output int nd);
      if (d == 1) begin
         if (p + 2 + size >= span) begin nd = 0; return span - size; end
         nd = 1; return p + 2;
      end
      if (p <= 2) begin nd = 1; return 0; end
      nd = 0; return p - 2;
   endfunction

   task automatic model_reset();
      mx = 100; my = 50; mdx = 1; mdy = 1;
      sb.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; VSYNC = 1'b1; valid = 1'b0; col = '0; row = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   // One frame: VSYNC low for 12 cycles; dut's expected position is pushed at the edge.
   task automatic do_frame();
      int lat;
      int ndx, ndy;
      logic [19:0] e;
      @(posedge clk); #1;
      if (enable) begin
         mx = model_axis(mx, mdx, 640, 16, ndx); mdx = ndx;
         my = model_axis(my, mdy, 480, 16, ndy); mdy = ndy;
         sb.push_back({10'(mx), 10'(my)});
      end
      VSYNC = 1'b0;
      lat = -1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (tick_a) begin
            cnt_a++;
            if (lat < 0) lat = c - 1;
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL sb_unexpected_tick x=%0d y=%0d required no tick", x_a, y_a);
            end else begin
               e = sb.pop_front();
               if ({x_a, y_a} !== e) begin
                  bad++;
                  $display("FAIL sb_pos got x=%0d y=%0d required x=%0d y=%0d",
                           x_a, y_a, e[19:10], e[9:0]);
               end
            end
         end
         if (tick_3) cnt_3++;
         if (tick_e) cnt_e++;
      end
      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL sb_missing_tick got none required %0d", sb.size());
         sb.delete();
      end
      last_lat = lat;
      @(posedge clk); #1 VSYNC = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset();
      enable = 1'b1;
      do_reset();
      @(negedge clk);
      total++; if (x_a !== 10'd100) begin bad++; $display("FAIL rst_x got %0d required 100", x_a); end
      total++; if (y_a !== 10'd50) begin bad++; $display("FAIL rst_y got %0d required 50", y_a); end
      total++; if (hit_a !== 1'b0) begin bad++; $display("FAIL rst_hit got %b required 0", hit_a); end
      total++; if (rgb_a !== 6'd0) begin bad++; $display("FAIL rst_rgb got %b required 0", rgb_a); end
      total++; if (tick_a !== 1'b0) begin bad++; $display("FAIL rst_tick got %b required 0", tick_a); end
   endtask

   task automatic test_first_frame();
      do_reset();
      cnt_a = 0;
      do_frame();
      total++; if (cnt_a != 1) begin bad++; $display("FAIL first_ticks got %0d required 1", cnt_a); end
      total++; if (last_lat != 4) begin bad++; $display("FAIL first_lat got %0d required 4", last_lat); end
      total++; if (x_a !== 10'd102 || y_a !== 10'd52) begin
         bad++; $display("FAIL first_pos got %0d/%0d required 102/52", x_a, y_a);
      end
   endtask

   task automatic test_pixel();
      logic [9:0] tc[6] = '{10'd100, 10'd116, 10'd99, 10'd115, 10'd115, 10'd100};
      logic [9:0] tr[6] = '{10'd50, 10'd50, 10'd50, 10'd65, 10'd66, 10'd50};
      logic       tv[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic       th[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [5:0] tg[6] = '{6'b110000, 6'd0, 6'd0, 6'b110000, 6'd0, 6'd0};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         col = tc[i]; row = tr[i]; valid = tv[i];
         @(posedge clk); @(negedge clk);
         total++;
         if (hit_a !== th[i] || rgb_a !== tg[i]) begin
            bad++;
            $display("FAIL pix%0d got hit=%b rgb=%b required hit=%b rgb=%b", i, hit_a, rgb_a, th[i], tg[i]);
         end
      end
      valid = 1'b0;
   endtask

   task automatic test_divider();
      do_reset();
      enable = 1'b1; cnt_3 = 0;
      repeat (6) do_frame();
      total++; if (cnt_3 != 2) begin bad++; $display("FAIL div_ticks got %0d required 2", cnt_3); end
      total++; if (x_3 !== 10'd104) begin bad++; $display("FAIL div_x got %0d required 104", x_3); end
      do_reset();
      enable = 1'b0; cnt_3 = 0; cnt_a = 0;
      repeat (6) do_frame();
      total++; if (cnt_3 != 0 || cnt_a != 0) begin
         bad++; $display("FAIL frozen_ticks got %0d/%0d required 0/0", cnt_3, cnt_a);
      end
      total++; if (x_3 !== 10'd100 || x_a !== 10'd100) begin
         bad++; $display("FAIL frozen_x got %0d/%0d required 100/100", x_3, x_a);
      end
      enable = 1'b1;
   endtask

   task automatic test_low_edges();
      int ex[3] = '{1, 0, 2};
      int ey[3] = '{2, 0, 2};
      do_reset();
      repeat (9) do_frame();
      for (int i = 0; i < 3; i++) begin
         do_frame();
         total++;
         if (x_e !== 10'(ex[i]) || y_e !== 10'(ey[i])) begin
            bad++;
            $display("FAIL edge_lt%0d got %0d/%0d required %0d/%0d", i, x_e, y_e, ex[i], ey[i]);
         end
      end
   endtask

   task automatic test_traverse();
      int px, pd;
      do_reset();
      for (int f = 0; f < 460; f++) begin
         px = mx; pd = mdx;
         do_frame();
         if (px == 622 && pd == 1) begin
            total++; if (x_a !== 10'd624) begin bad++; $display("FAIL right_edge got %0d required 624", x_a); end
         end
         if (px == 624 && pd == 0) begin
            total++; if (x_a !== 10'd622) begin bad++; $display("FAIL right_back got %0d required 622", x_a); end
         end
         if (my == 464 && mdy == 0 && pd == 1) begin
            total++; if (y_a !== 10'd464) begin bad++; $display("FAIL bottom_edge got %0d required 464", y_a); end
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      cnt_a = 0;
      @(posedge clk); #1 VSYNC = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      total++; if (x_a !== 10'd100 || y_a !== 10'd50) begin
         bad++; $display("FAIL async_pos got %0d/%0d required 100/50", x_a, y_a);
      end
      total++; if (tick_a !== 1'b0 || hit_a !== 1'b0) begin
         bad++; $display("FAIL async_flags got tick=%b hit=%b required 0/0", tick_a, hit_a);
      end
      VSYNC = 1'b1;
      @(posedge clk); #1 rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (tick_a) cnt_a++;
      end
      total++; if (cnt_a != 0 || x_a !== 10'd100 || y_a !== 10'd50) begin
         bad++; $display("FAIL async_after got tick=%0d pos=%0d/%0d required 0 100/50", cnt_a, x_a, y_a);
      end
      do_frame();
      total++; if (last_lat != 4 || x_a !== 10'd102) begin
         bad++; $display("FAIL async_idle got lat=%0d x=%0d required 4 102", last_lat, x_a);
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_pixel();
      test_divider();
      test_low_edges();
      test_traverse();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
